// File: rtl/ledpattern_if.sv
// Host-side signal bundle for the LED pattern engine: mode/rate/manual controls in, LED drive and step strobe out.
interface ledpattern_if #(
  parameter int NLEDS   = 8,
  parameter int CTRBITS = 25
);
  logic [1:0]         i_mode;
  logic [CTRBITS-1:0] i_rate;
  logic [NLEDS-1:0]   i_manual;
  logic [NLEDS-1:0]   o_leds;
  logic               o_tick;

  modport master (
    output i_mode, i_rate, i_manual,
    input  o_leds, o_tick
  );

  modport slave (
    input  i_mode, i_rate, i_manual,
    output o_leds, o_tick
  );
endinterface

// File: rtl/ledpattern.sv
// PWM-dimmed LED pattern engine: bounce, circular chase, manual and all-off patterns with afterglow decay.
// Define LEDPATTERN_BITREV_EN to compare against the bit-reversed PWM counter (spreads on-time, same duty).
//
// dir state | meaning
// DIR_UP    | bounce owner travelling toward LED NLEDS-1
// DIR_DOWN  | bounce owner travelling toward LED 0
module ledpattern #(
  parameter int NLEDS   = 8,
  parameter int CTRBITS = 25,
  parameter int PWMBITS = 5,
  parameter int DECAY   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  ledpattern_if.slave io_bus
);

  typedef enum logic [1:0] {MODE_BOUNCE, MODE_CHASE, MODE_MANUAL, MODE_OFF} mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [PWMBITS-1:0] LMAX_V    = '1;
  localparam logic [NLEDS-1:0]   OWNER_RST = NLEDS'(1);

  logic [CTRBITS-1:0]              r_acc;
  logic                            r_tick;
  logic [NLEDS-1:0]                r_owner;
  dir_t                            r_dir;
  logic [NLEDS-1:0][PWMBITS-1:0]   r_level;
  logic [PWMBITS-1:0]              r_pwm_ctr;
  logic [NLEDS-1:0]                r_leds;

  logic [CTRBITS:0]                w_sum;
  mode_t                           w_mode;
  logic [NLEDS-1:0]                w_owner_nxt;
  dir_t                            w_dir_nxt;
  logic [NLEDS-1:0][PWMBITS:0]     w_sub;
  logic [NLEDS-1:0][PWMBITS-1:0]   w_level_nxt;
  logic [PWMBITS-1:0]              w_cmp;
  logic [NLEDS-1:0]                w_leds;

  assign w_sum  = {1'b0, r_acc} + {1'b0, io_bus.i_rate};
  assign w_mode = mode_t'(io_bus.i_mode);

`ifdef LEDPATTERN_BITREV_EN
  always_comb begin
    w_cmp = '0;
    for (int b = 0; b < PWMBITS; b++) w_cmp[b] = r_pwm_ctr[PWMBITS-1-b];
  end
`else
  assign w_cmp = r_pwm_ctr;
`endif

  // A corrupted owner (zero or multi-hot) is repaired here rather than on mode change.
  always_comb begin
    w_owner_nxt = r_owner;
    w_dir_nxt   = r_dir;
    case (w_mode)
      MODE_BOUNCE: begin
        if (!$onehot(r_owner)) begin
          w_owner_nxt = OWNER_RST;
          w_dir_nxt   = DIR_UP;
        end else if (r_dir == DIR_UP) begin
          if (r_owner[NLEDS-1]) w_dir_nxt = DIR_DOWN;
          else                  w_owner_nxt = r_owner << 1;
        end else begin
          if (r_owner[0]) w_dir_nxt = DIR_UP;
          else            w_owner_nxt = r_owner >> 1;
        end
      end
      MODE_CHASE: begin
        if (!$onehot(r_owner)) w_owner_nxt = OWNER_RST;
        else                   w_owner_nxt = {r_owner[NLEDS-2:0], r_owner[NLEDS-1]};
      end
      MODE_MANUAL: w_owner_nxt = io_bus.i_manual;
      default:     w_owner_nxt = '0;
    endcase
  end

  always_comb begin
    w_sub       = '0;
    w_level_nxt = r_level;
    w_leds      = '0;
    for (int k = 0; k < NLEDS; k++) begin
      w_sub[k] = {1'b0, r_level[k] >> DECAY} + (PWMBITS+1)'(1);
      if (r_owner[k])                       w_level_nxt[k] = LMAX_V;
      else if ({1'b0, r_level[k]} <= w_sub[k]) w_level_nxt[k] = '0;
      else                                  w_level_nxt[k] = r_level[k] - w_sub[k][PWMBITS-1:0];

      if (r_level[k] == LMAX_V)   w_leds[k] = 1'b1;
      else if (r_level[k] == '0)  w_leds[k] = 1'b0;
      else                        w_leds[k] = (w_cmp < r_level[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc     <= '0;
      r_tick    <= 1'b0;
      r_owner   <= OWNER_RST;
      r_dir     <= DIR_UP;
      r_level   <= '0;
      r_pwm_ctr <= '0;
      r_leds    <= '0;
    end else begin
      {r_tick, r_acc} <= w_sum;
      r_pwm_ctr       <= r_pwm_ctr + PWMBITS'(1);
      r_leds          <= w_leds;
      if (r_tick) begin
        r_owner <= w_owner_nxt;
        r_dir   <= w_dir_nxt;
        r_level <= w_level_nxt;
      end
    end
  end

  assign io_bus.o_leds = r_leds;
  assign io_bus.o_tick = r_tick;

endmodule

// File: tb/tb_ledpattern.sv
// Self-checking bench for ledpattern: directed pattern/decay/PWM scenarios plus randomized run against a reference model.
module tb_ledpattern;
  localparam int NLEDS   = 8;
  localparam int CTRBITS = 4;
  localparam int PWMBITS = 5;
  localparam int DECAY   = 2;
  localparam int LMAX    = (1 << PWMBITS) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ledpattern_if #(.NLEDS(NLEDS), .CTRBITS(CTRBITS)) u_if ();

  ledpattern #(.NLEDS(NLEDS), .CTRBITS(CTRBITS), .PWMBITS(PWMBITS), .DECAY(DECAY)) u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_bus    (u_if.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  int               m_acc;
  logic             m_tick;
  logic [NLEDS-1:0] m_owner;
  logic             m_up;
  int               m_level [NLEDS];
  int               m_pwm;
  logic [NLEDS-1:0] m_leds;

  function automatic int f_cmp(int c);
`ifdef LEDPATTERN_BITREV_EN
    int r = 0;
    for (int b = 0; b < PWMBITS; b++) if (((c >> b) & 1) == 1) r = r | (1 << (PWMBITS-1-b));
    return r;
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    m_acc = 0; m_tick = 1'b0; m_owner = NLEDS'(1); m_up = 1'b1; m_pwm = 0; m_leds = '0;
    for (int k = 0; k < NLEDS; k++) m_level[k] = 0;
  endtask

  task automatic model_step();
    int sum, pos;
    logic [NLEDS-1:0] nleds;
    int nlev [NLEDS];
    sum = m_acc + int'(u_if.i_rate);
    for (int k = 0; k < NLEDS; k++)
      nleds[k] = (m_level[k] == LMAX) ? 1'b1 : (m_level[k] == 0) ? 1'b0 : (f_cmp(m_pwm) < m_level[k]);
    nlev = m_level;
    if (m_tick) begin
      for (int k = 0; k < NLEDS; k++) begin
        if (m_owner[k]) nlev[k] = LMAX;
        else begin
          nlev[k] = m_level[k] - (m_level[k] / (1 << DECAY) + 1);
          if (nlev[k] < 0) nlev[k] = 0;
        end
      end
      pos = -1;
      for (int k = 0; k < NLEDS; k++) if (m_owner[k]) pos = k;
      case (u_if.i_mode)
        2'd0: begin
          if ($countones(m_owner) != 1) begin m_owner = NLEDS'(1); m_up = 1'b1; end
          else if (m_up) begin
            if (pos == NLEDS-1) m_up = 1'b0; else m_owner = m_owner << 1;
          end else begin
            if (pos == 0) m_up = 1'b1; else m_owner = m_owner >> 1;
          end
        end
        2'd1: begin
          if ($countones(m_owner) != 1) m_owner = NLEDS'(1);
          else m_owner = (pos == NLEDS-1) ? NLEDS'(1) : (m_owner << 1);
        end
        2'd2:    m_owner = u_if.i_manual;
        default: m_owner = '0;
      endcase
    end
    m_level = nlev;
    m_acc   = sum % (1 << CTRBITS);
    m_tick  = (sum >= (1 << CTRBITS));
    m_pwm   = (m_pwm + 1) % (LMAX + 1);
    m_leds  = nleds;
  endtask

  // one clock; returns at the following negedge with the model advanced in lockstep
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // cycles until o_tick is seen high, or -1 if it never arrives
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (u_if.o_tick !== 1'b1 && cyc < 64);
    if (u_if.o_tick !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    int bad_tick, bad_leds;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (u_if.o_leds !== '0 || u_if.o_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_initial: leds=%h tick=%b, want leds=00 tick=0", u_if.o_leds, u_if.o_tick);
    end
    do_reset();
    u_if.i_mode = 2'd1; u_if.i_rate = CTRBITS'(4);
    repeat (60) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (u_if.o_leds !== '0 || u_if.o_tick !== 1'b0 || u_dut.r_owner !== NLEDS'(1)) begin
      n_fail++; $display("FAIL reset_midrun: leds=%h tick=%b owner=%h, want 00 0 01", u_if.o_leds, u_if.o_tick, u_dut.r_owner);
    end
    u_if.i_rate = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_tick = 0; bad_leds = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (u_if.o_tick !== 1'b0) bad_tick++;
      if (u_if.o_leds !== '0) bad_leds++;
    end
    n_tests++;
    if (bad_tick != 0) begin n_fail++; $display("FAIL reset_no_tick: %0d tick cycles, want 0", bad_tick); end
    n_tests++;
    if (bad_leds != 0) begin n_fail++; $display("FAIL reset_leds_off: %0d lit cycles, want 0", bad_leds); end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_owner [17] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01, 8'h02};
    int cyc;
    do_reset();
    u_if.i_mode = 2'd0; u_if.i_rate = CTRBITS'(4);
    for (int i = 0; i < 17; i++) begin
      wait_tick(cyc);
      n_tests++;
      if (cyc != ((i == 0) ? 4 : 3)) begin
        n_fail++; $display("FAIL bounce_period[%0d]: waited %0d, want %0d", i, cyc, (i == 0) ? 4 : 3);
      end
      step();
      n_tests++;
      if (u_dut.r_owner !== exp_owner[i]) begin
        n_fail++; $display("FAIL bounce_owner[%0d]: got %h, want %h", i, u_dut.r_owner, exp_owner[i]);
      end
      n_tests++;
      if (u_if.o_leds !== m_leds) begin
        n_fail++; $display("FAIL bounce_leds[%0d]: got %h, want %h", i, u_if.o_leds, m_leds);
      end
    end
  endtask

  task automatic test_chase();
    logic [7:0] exp_owner [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    int cyc;
    do_reset();
    u_if.i_mode = 2'd1; u_if.i_rate = CTRBITS'(4);
    for (int i = 0; i < 9; i++) begin
      wait_tick(cyc);
      step();
      n_tests++;
      if (cyc < 0 || u_dut.r_owner !== exp_owner[i]) begin
        n_fail++; $display("FAIL chase_owner[%0d]: got %h (wait %0d), want %h", i, u_dut.r_owner, cyc, exp_owner[i]);
      end
    end
    u_if.i_mode = 2'd2; u_if.i_manual = 8'h0A;
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_owner !== 8'h0A) begin n_fail++; $display("FAIL manual_owner: got %h, want 0a", u_dut.r_owner); end
    u_if.i_mode = 2'd1;
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_owner !== 8'h01) begin n_fail++; $display("FAIL chase_repair: got %h, want 01", u_dut.r_owner); end
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_owner !== 8'h02) begin n_fail++; $display("FAIL chase_after_repair: got %h, want 02", u_dut.r_owner); end
  endtask

  task automatic test_decay();
    int exp_lvl [10] = '{23, 17, 12, 8, 5, 3, 2, 1, 0, 0};
    int cyc;
    do_reset();
    u_if.i_mode = 2'd2; u_if.i_manual = 8'h01; u_if.i_rate = CTRBITS'(4);
    wait_tick(cyc); step();
    u_if.i_manual = 8'h00;
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_level[0] !== PWMBITS'(LMAX)) begin
      n_fail++; $display("FAIL decay_start: got %0d, want %0d", u_dut.r_level[0], LMAX);
    end
    for (int i = 0; i < 10; i++) begin
      wait_tick(cyc); step();
      n_tests++;
      if (cyc < 0 || u_dut.r_level[0] !== PWMBITS'(exp_lvl[i])) begin
        n_fail++; $display("FAIL decay_level[%0d]: got %0d, want %0d", i, u_dut.r_level[0], exp_lvl[i]);
      end
      n_tests++;
      if (u_if.o_leds !== m_leds) begin
        n_fail++; $display("FAIL decay_leds[%0d]: got %h, want %h", i, u_if.o_leds, m_leds);
      end
    end
  endtask

  task automatic test_pwm_duty();
    int cyc, highs, others, run, max_run;
    do_reset();
    u_if.i_mode = 2'd2; u_if.i_manual = 8'h01; u_if.i_rate = CTRBITS'(8);
    wait_tick(cyc);
    n_tests++;
    if (cyc != 2) begin n_fail++; $display("FAIL half_rate_first: waited %0d, want 2", cyc); end
    step();
    u_if.i_manual = 8'h00;
    wait_tick(cyc);
    n_tests++;
    if (cyc != 1) begin n_fail++; $display("FAIL half_rate_period: waited %0d, want 1", cyc); end
    step();
    repeat (3) begin wait_tick(cyc); step(); end
    u_if.i_rate = '0;
    n_tests++;
    if (u_dut.r_level[0] !== PWMBITS'(12)) begin
      n_fail++; $display("FAIL pwm_level: got %0d, want 12", u_dut.r_level[0]);
    end
    repeat (2) step();
    highs = 0; others = 0; run = 0; max_run = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (u_if.o_leds[0] === 1'b1) begin highs++; run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (u_if.o_leds[NLEDS-1:1] !== '0) others++;
    end
    n_tests++;
    if (highs != 24) begin n_fail++; $display("FAIL pwm_duty: %0d high of 64, want 24", highs); end
    n_tests++;
    if (others != 0) begin n_fail++; $display("FAIL pwm_dark_leds: %0d lit cycles, want 0", others); end
`ifdef LEDPATTERN_BITREV_EN
    n_tests++;
    if (max_run > 1) begin n_fail++; $display("FAIL pwm_spread: run %0d, want <= 1", max_run); end
`else
    n_tests++;
    if (max_run != 12) begin n_fail++; $display("FAIL pwm_contiguous: run %0d, want 12", max_run); end
`endif
  endtask

  task automatic test_all_off();
    int cyc, bad;
    do_reset();
    u_if.i_mode = 2'd2; u_if.i_manual = 8'hFF; u_if.i_rate = CTRBITS'(4);
    wait_tick(cyc); step();
    wait_tick(cyc); step();
    u_if.i_mode = 2'd3;
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_level !== {NLEDS{PWMBITS'(LMAX)}} || u_dut.r_owner !== '0) begin
      n_fail++; $display("FAIL off_start: levels=%h owner=%h, want all %0d owner 00", u_dut.r_level, u_dut.r_owner, LMAX);
    end
    n_tests++;
    if (u_if.o_leds !== 8'hFF) begin n_fail++; $display("FAIL off_full_on: got %h, want ff", u_if.o_leds); end
    repeat (8) begin wait_tick(cyc); step(); end
    n_tests++;
    if (u_dut.r_level !== {NLEDS{PWMBITS'(1)}}) begin
      n_fail++; $display("FAIL off_tick8: levels=%h, want all 1", u_dut.r_level);
    end
    wait_tick(cyc); step();
    n_tests++;
    if (u_dut.r_level !== '0) begin n_fail++; $display("FAIL off_tick9: levels=%h, want 0", u_dut.r_level); end
    step();
    bad = 0;
    for (int i = 0; i < 64; i++) begin step(); if (u_if.o_leds !== '0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL off_dark: %0d lit cycles, want 0", bad); end
  endtask

  task automatic test_random();
    do_reset();
    u_if.i_mode = 2'd0; u_if.i_rate = CTRBITS'(4); u_if.i_manual = '0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) rst_n = 1'b0;
      if (i == 2003) rst_n = 1'b1;
      if ($urandom_range(0, 49) == 0) u_if.i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) u_if.i_manual = NLEDS'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0:       u_if.i_rate = '0;
          1:       u_if.i_rate = CTRBITS'(4);
          2:       u_if.i_rate = CTRBITS'(8);
          default: u_if.i_rate = CTRBITS'($urandom_range(1, (1 << CTRBITS) - 1));
        endcase
      end
      step();
      n_tests++;
      if (u_if.o_tick !== m_tick) begin
        n_fail++; $display("FAIL rand_tick@%0d: got %b, want %b", i, u_if.o_tick, m_tick);
      end
      n_tests++;
      if (u_if.o_leds !== m_leds) begin
        n_fail++; $display("FAIL rand_leds@%0d: got %h, want %h", i, u_if.o_leds, m_leds);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.i_mode = 2'd0; u_if.i_rate = '0; u_if.i_manual = '0;
    test_reset();
    test_bounce();
    test_chase();
    test_decay();
    test_pwm_duty();
    test_all_off();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ledpattern.md
# ledpattern

Parametrised LED pattern engine; successor to the fixed-width bouncer. Drives NLEDS PWM-dimmed LEDs with bounce, circular-chase or host-supplied patterns, a run-time step rate, a parametrised brightness depth and a parametrised afterglow decay. Sits at the board top level between the bus-controlled mode/rate registers and the LED pins.

## Interface
- NLEDS, 8, number of LEDs (≥2)
- CTRBITS, 25, width of step-rate accumulator and of i_rate
- PWMBITS, 5, brightness resolution per LED (≥2); full-on level LMAX = 2^PWMBITS−1
- DECAY, 2, afterglow shift; larger means slower fade
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; one clock, asynchronous active-low
- i_mode  in  2  0 = bounce, 1 = chase (circular), 2 = manual, 3 = all off
- i_rate  in  CTRBITS  step increment added to accumulator every clock
- i_manual  in  NLEDS  owner pattern used in manual mode
- o_leds  out  NLEDS  PWM LED drive, registered
- o_tick  out  1  one-cycle strobe, high on the cycle a pattern step is applied

## Operation
- Reset (async assert, sync release): acc=0, o_tick=0, owner=1 (bit 0), dir=up, all levels=0, pwm_ctr=0, o_leds=0.
- Step timer: {carry, acc} <= acc + i_rate each clock; o_tick <= carry. i_rate=0 → no ticks; i_rate=2^(CTRBITS−1) → tick every 2nd cycle.
- Owner update occurs only on clocks where o_tick=1; i_mode and i_manual sampled on that same edge.
- Bounce: if owner not one-hot → owner=1, dir=up. Else dir up: at bit NLEDS−1 flip dir (owner holds one step), else shift left. Dir down: at bit 0 flip dir (hold), else shift right.
- Chase: if owner not one-hot → owner=1. Else rotate left, bit NLEDS−1 wraps to bit 0. dir unchanged.
- Manual: owner <= i_manual (any value, including zero or multi-hot). dir unchanged.
- All off: owner <= 0; levels decay normally.
- Levels, on tick, per LED k (after owner update uses the pre-update owner): owner[k] → LMAX; else level <= level − ((level>>DECAY)+1), saturating at 0. Arithmetic PWMBITS+1 bits wide, no wrap.
- PWM: pwm_ctr free-runs PWMBITS wide, wraps at LMAX→0. cmp = pwm_ctr (see Configuration). o_leds[k] <= 1 if level=LMAX, 0 if level=0, else (cmp < level). Duty = level/2^PWMBITS except LMAX → 100%.
- Mode change mid-pattern: no reset of dir/levels; owner repaired only by the one-hot check on next tick.

## Timing
- Tick latency: carry at edge n → o_tick high cycle n+1; owner/levels update on edge n+1 (same edge sees o_tick=1).
- o_leds reflects a new level one clock after the level register changes.
- Reset mid-operation: all state returns to reset values immediately; first tick after release no earlier than the clock where acc overflows.
- Simultaneous tick and mode change: new mode applied on that tick.
- No combinational path from inputs to outputs.

## Configuration
- LEDPATTERN_BITREV_EN defined: cmp = bit-reversed pwm_ctr (MSB↔LSB), spreading on-time across the PWM period to reduce visible flicker.
- Not defined: cmp = pwm_ctr directly; single contiguous on-pulse per period. Duty cycles identical either way.

## Test plan
- Reset: hold i_reset_n=0 mid-run, NLEDS=8 → o_leds=0, o_tick=0 immediately; after release with i_rate=0, no tick for 1000 cycles, o_leds stays 0.
- Bounce, CTRBITS=4, i_rate=4 → o_tick every 4 cycles; owner sequence 01,02,04,…,80,80(hold),40,…,01,01(hold),02.
- Chase, same rate → owner 01,02,…,80,01; inject i_manual=0x0A in manual then switch to chase → owner=01 on first chase tick.
- Decay, PWMBITS=5, DECAY=2: LED leaves ownership → level per tick 31,23,17,12,8,5,3,2,1,0, then stays 0.
- PWM duty: manual level held at 12 (freeze i_rate=0 after decay) → o_leds[k] high exactly 12 of every 32 cycles, both with and without LEDPATTERN_BITREV_EN; with it, no run of more than 1 consecutive high cycle.
- Mode 3 with all LEDs at 31 → all decay to 0 in 9 ticks; o_leds=0 thereafter.
